host_pkt_assembler: RTL and testbench

//  Host-domain stage directly downstream of the FIFO read/unpack stage. Consumes its beat stream
//  (valid/sop/eop/length/buffer/64b data), writes each packet's beats into host packet RAM
//  and queues one completion descriptor per packet, with byte count and error code.

---
 rtl/host_pkt_pkg.sv | 29 ++
 rtl/host_desc_fifo.sv | 61 ++++++
 rtl/host_pkt_assembler.sv | 231 +++++++++++++++++++++++
 tb/tb_host_pkt_assembler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/host_pkt_pkg.sv
// Shared types and defaults for the host packet assembler.
// Imported by the descriptor FIFO and the assembler top.
package host_pkt_pkg;

   localparam int MAX_BEATS_DEF  = 190;
   localparam int BYTES_W_DEF    = 11;
   localparam int DESC_DEPTH_DEF = 4;
   localparam int IDX_W          = 8;

   typedef enum logic [1:0] {
      ERR_OK           = 2'd0,
      ERR_TRUNC        = 2'd1,
      ERR_OVERSIZE     = 2'd2,
      ERR_BUF_MISMATCH = 2'd3
   } err_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      DISCARD = 2'd2
   } state_e;

   typedef struct packed {
      logic [7:0]             buffer;
      logic [BYTES_W_DEF-1:0] bytes;
      err_e                   err;
   } desc_t;

endpackage

// File: rtl/host_desc_fifo.sv
// Show-ahead descriptor FIFO with two ordered push slots per cycle.
// Slot a always lands before slot b; a full FIFO still accepts if a pop frees room.
module host_desc_fifo
   import host_pkt_pkg::*;
#(
   parameter int DEPTH = DESC_DEPTH_DEF
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  push_a,
   input  desc_t din_a,
   input  logic  push_b,
   input  desc_t din_b,
   input  logic  pop,
   output desc_t dout,
   output logic  full,
   output logic  empty,
   output logic  acc_b
);

   localparam int AW = $clog2(DEPTH);

   desc_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] wr_ptr_b;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW+1:0] space;
   logic          do_pop;
   logic          acc_a;

   assign empty  = (count == '0);
   assign full   = (count == (AW+1)'(DEPTH));
   assign do_pop = pop && !empty;

   // Room this cycle counts the slot a same-cycle pop releases.
   assign space    = (AW+2)'(DEPTH) - (AW+2)'(count) + (AW+2)'(do_pop);
   assign acc_a    = push_a && (space != '0);
   assign acc_b    = push_b && (space > (AW+2)'(acc_a));
   assign wr_ptr_b = wr_ptr + AW'(acc_a);
   assign dout     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (acc_a) mem[wr_ptr] <= din_a;
      if (acc_b) mem[wr_ptr_b] <= din_b;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(acc_a) + AW'(acc_b);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count  <= count + (AW+1)'(acc_a) + (AW+1)'(acc_b)
                   - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/host_pkt_assembler.sv
// Host-side packet assembler: writes beats to packet RAM, queues
// one completion descriptor per packet, flags framing errors.
module host_pkt_assembler
   import host_pkt_pkg::*;
#(
   parameter int MAX_BEATS  = MAX_BEATS_DEF,
   parameter int BYTES_W    = BYTES_W_DEF,
   parameter int DESC_DEPTH = DESC_DEPTH_DEF
) (
   input  logic               clk_host,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [63:0]        in_data,
   input  logic [2:0]         in_length,
   input  logic [7:0]         in_buffer,
   input  logic               in_sop,
   input  logic               in_eop,
   output logic               mem_wr_en,
   output logic [15:0]        mem_wr_addr,
   output logic [63:0]        mem_wr_data,
   output logic               desc_valid,
   input  logic               desc_ready,
   output logic [7:0]         desc_buffer,
   output logic [BYTES_W-1:0] desc_bytes,
   output logic [1:0]         desc_err,
   output logic [31:0]        cnt_pkts,
   output logic [15:0]        cnt_errs,
   output logic [15:0]        cnt_drops
);

   state_e             state;
   state_e             nxt_state;
   logic [7:0]         cur_buf;
   logic [7:0]         nxt_buf;
   logic [IDX_W-1:0]   beat_idx;
   logic [IDX_W-1:0]   nxt_idx;
   logic [BYTES_W-1:0] byte_cnt;
   logic [BYTES_W-1:0] nxt_bytes;
   logic [BYTES_W-1:0] eop_bytes;

   logic               wr;
   logic [15:0]        wr_addr;
   logic               start;
   logic               push_a;
   logic               push_b;
   desc_t              desc_a;
   desc_t              desc_b;
   logic               err_evt;
   logic               ok_evt;
   logic               mism;
   logic               over;

   logic               pop;
   logic               full;
   logic               empty;
   logic               acc_b;
   logic               drop_a;
   logic               drop_b;
   logic [16:0]        drop_sum;
   desc_t              head;

   function automatic desc_t mk_desc(input logic [7:0]         b,
                                     input logic [BYTES_W-1:0] n,
                                     input err_e               e);
      desc_t d;
      d.buffer = b;
      d.bytes  = BYTES_W_DEF'(n);
      d.err    = e;
      return d;
   endfunction

   assign eop_bytes = BYTES_W'(in_length) + BYTES_W'(1);
   assign mism      = (in_buffer != cur_buf);
   assign over      = (beat_idx == IDX_W'(MAX_BEATS));

   always_ff @(posedge clk_host) begin
      if (!rst_n) begin
         state    <= IDLE;
         cur_buf  <= '0;
         beat_idx <= '0;
         byte_cnt <= '0;
      end else begin
         state    <= nxt_state;
         cur_buf  <= nxt_buf;
         beat_idx <= nxt_idx;
         byte_cnt <= nxt_bytes;
      end
   end

   always_comb begin
      nxt_state = state;
      if (in_valid) begin
         unique case (state)
            IDLE: begin
               if (in_sop && !in_eop) nxt_state = ACTIVE;
            end
            ACTIVE: begin
               if (in_sop)            nxt_state = in_eop ? IDLE : ACTIVE;
               else if (mism || over) nxt_state = in_eop ? IDLE : DISCARD;
               else if (in_eop)       nxt_state = IDLE;
            end
            DISCARD: begin
               if (in_sop)      nxt_state = in_eop ? IDLE : ACTIVE;
               else if (in_eop) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
         endcase
      end
   end

   always_comb begin
      wr        = 1'b0;
      wr_addr   = '0;
      start     = 1'b0;
      push_a    = 1'b0;
      push_b    = 1'b0;
      desc_a    = '0;
      desc_b    = '0;
      err_evt   = 1'b0;
      nxt_buf   = cur_buf;
      nxt_idx   = beat_idx;
      nxt_bytes = byte_cnt;
      if (in_valid) begin
         unique case (state)
            IDLE: begin
               if (in_sop) start = 1'b1;
               else        err_evt = 1'b1;
            end
            ACTIVE: begin
               if (in_sop) begin
                  push_a  = 1'b1;
                  desc_a  = mk_desc(cur_buf, byte_cnt, ERR_TRUNC);
                  err_evt = 1'b1;
                  start   = 1'b1;
               end else if (mism) begin
                  push_a  = 1'b1;
                  desc_a  = mk_desc(cur_buf, byte_cnt, ERR_BUF_MISMATCH);
                  err_evt = 1'b1;
               end else if (over) begin
                  push_a  = 1'b1;
                  desc_a  = mk_desc(cur_buf, BYTES_W'(MAX_BEATS * 8),
                                    ERR_OVERSIZE);
                  err_evt = 1'b1;
               end else begin
                  wr      = 1'b1;
                  wr_addr = {cur_buf, beat_idx};
                  nxt_idx = beat_idx + IDX_W'(1);
                  if (in_eop) begin
                     push_a = 1'b1;
                     desc_a = mk_desc(cur_buf, byte_cnt + eop_bytes, ERR_OK);
                  end else begin
                     nxt_bytes = byte_cnt + BYTES_W'(8);
                  end
               end
            end
            DISCARD: begin
               if (in_sop) start = 1'b1;
            end
            default: ;
         endcase
         // A new packet may close the old one and complete itself in one beat.
         if (start) begin
            wr      = 1'b1;
            wr_addr = {in_buffer, 8'd0};
            nxt_buf = in_buffer;
            if (in_eop) begin
               push_b = 1'b1;
               desc_b = mk_desc(in_buffer, eop_bytes, ERR_OK);
            end else begin
               nxt_idx   = IDX_W'(1);
               nxt_bytes = BYTES_W'(8);
            end
         end
      end
   end

   assign ok_evt = push_b || (push_a && desc_a.err == ERR_OK);
   assign pop    = desc_ready && !empty;

   host_desc_fifo #(
      .DEPTH (DESC_DEPTH)
   ) u_fifo (
      .clk    (clk_host),
      .rst_n  (rst_n),
      .push_a (push_a),
      .din_a  (desc_a),
      .push_b (push_b),
      .din_b  (desc_b),
      .pop    (pop),
      .dout   (head),
      .full   (full),
      .empty  (empty),
      .acc_b  (acc_b)
   );

   assign drop_a   = push_a && full && !pop;
   assign drop_b   = push_b && !acc_b;
   assign drop_sum = {1'b0, cnt_drops} + 17'(drop_a) + 17'(drop_b);

   assign desc_valid  = !empty;
   assign desc_buffer = desc_valid ? head.buffer : '0;
   assign desc_bytes  = desc_valid ? BYTES_W'(head.bytes) : '0;
   assign desc_err    = desc_valid ? head.err : ERR_OK;

   always_ff @(posedge clk_host) begin
      if (!rst_n) begin
         mem_wr_en   <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
      end else begin
         mem_wr_en <= wr;
         if (wr) begin
            mem_wr_addr <= wr_addr;
            mem_wr_data <= in_data;
         end
      end
   end

   always_ff @(posedge clk_host) begin
      if (!rst_n) begin
         cnt_pkts  <= '0;
         cnt_errs  <= '0;
         cnt_drops <= '0;
      end else begin
         if (ok_evt && cnt_pkts != '1)  cnt_pkts <= cnt_pkts + 32'd1;
         if (err_evt && cnt_errs != '1) cnt_errs <= cnt_errs + 16'd1;
         cnt_drops <= drop_sum[16] ? '1 : drop_sum[15:0];
      end
   end

endmodule

// File: tb/tb_host_pkt_assembler.sv
// Directed bench for host_pkt_assembler with hand-computed expectations.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_host_pkt_assembler;
   import host_pkt_pkg::*;

   logic        clk_host = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] in_data;
   logic [2:0]  in_length;
   logic [7:0]  in_buffer;
   logic        in_sop;
   logic        in_eop;
   logic        mem_wr_en;
   logic [15:0] mem_wr_addr;
   logic [63:0] mem_wr_data;
   logic        desc_valid;
   logic        desc_ready;
   logic [7:0]  desc_buffer;
   logic [10:0] desc_bytes;
   logic [1:0]  desc_err;
   logic [31:0] cnt_pkts;
   logic [15:0] cnt_errs;
   logic [15:0] cnt_drops;

   int errors   = 0;
   int checks   = 0;
   int wr_count = 0;
   int wr_base;

   host_pkt_assembler dut (
      .clk_host    (clk_host),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_length   (in_length),
      .in_buffer   (in_buffer),
      .in_sop      (in_sop),
      .in_eop      (in_eop),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .desc_valid  (desc_valid),
      .desc_ready  (desc_ready),
      .desc_buffer (desc_buffer),
      .desc_bytes  (desc_bytes),
      .desc_err    (desc_err),
      .cnt_pkts    (cnt_pkts),
      .cnt_errs    (cnt_errs),
      .cnt_drops   (cnt_drops)
   );

   always #5 clk_host = ~clk_host;

   always @(posedge clk_host) if (mem_wr_en) wr_count++;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_desc(input string tag, input logic [7:0] b,
                           input logic [10:0] n, input logic [1:0] e);
      check({tag, ".valid"}, 64'(desc_valid), 64'd1);
      check({tag, ".buf"}, 64'(desc_buffer), 64'(b));
      check({tag, ".bytes"}, 64'(desc_bytes), 64'(n));
      check({tag, ".err"}, 64'(desc_err), 64'(e));
   endtask

   task automatic send(input logic sop, input logic eop, input logic [7:0] b,
                       input logic [2:0] len, input logic [63:0] d);
      in_valid  = 1'b1;
      in_sop    = sop;
      in_eop    = eop;
      in_buffer = b;
      in_length = len;
      in_data   = d;
      @(negedge clk_host);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
   endtask

   task automatic pop_one();
      desc_ready = 1'b1;
      @(negedge clk_host);
      desc_ready = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_length  = '0;
      in_buffer  = '0;
      in_sop     = 1'b0;
      in_eop     = 1'b0;
      desc_ready = 1'b0;
      repeat (3) @(negedge clk_host);
      check("rst.wr_en", 64'(mem_wr_en), 64'd0);
      check("rst.desc_valid", 64'(desc_valid), 64'd0);
      check("rst.pkts", 64'(cnt_pkts), 64'd0);
      check("rst.errs", 64'(cnt_errs), 64'd0);
      check("rst.drops", 64'(cnt_drops), 64'd0);
      rst_n = 1'b1;
      @(negedge clk_host);

      // 3-beat packet on buffer 0x12: 8 + 8 + 4 bytes
      send(1, 0, 8'h12, 3'd0, 64'h1111_0000_0000_0001);
      check("t1.wr0", 64'(mem_wr_en), 64'd1);
      check("t1.addr0", 64'(mem_wr_addr), 64'h1200);
      check("t1.data0", mem_wr_data, 64'h1111_0000_0000_0001);
      send(0, 0, 8'h12, 3'd0, 64'h2222_0000_0000_0002);
      check("t1.addr1", 64'(mem_wr_addr), 64'h1201);
      send(0, 1, 8'h12, 3'd3, 64'h3333_0000_0000_0003);
      check("t1.addr2", 64'(mem_wr_addr), 64'h1202);
      check("t1.data2", mem_wr_data, 64'h3333_0000_0000_0003);
      chk_desc("t1", 8'h12, 11'd20, 2'd0);
      check("t1.pkts", 64'(cnt_pkts), 64'd1);
      pop_one();
      check("t1.popped", 64'(desc_valid), 64'd0);

      // single-beat packet, length 7 -> 8 bytes
      wr_base = wr_count;
      send(1, 1, 8'h34, 3'd7, 64'hABCD);
      check("t2.addr", 64'(mem_wr_addr), 64'h3400);
      chk_desc("t2", 8'h34, 11'd8, 2'd0);
      @(negedge clk_host);
      check("t2.nwr", 64'(wr_count - wr_base), 64'd1);
      pop_one();

      // sop while active truncates the open packet
      send(1, 0, 8'h07, 3'd0, 64'h70);
      send(0, 0, 8'h07, 3'd0, 64'h71);
      send(1, 0, 8'h05, 3'd0, 64'h50);
      check("t3.addr", 64'(mem_wr_addr), 64'h0500);
      chk_desc("t3.trunc", 8'h07, 11'd16, 2'd1);
      check("t3.errs", 64'(cnt_errs), 64'd1);
      desc_ready = 1'b1;
      send(0, 1, 8'h05, 3'd1, 64'h51);
      desc_ready = 1'b0;
      check("t3.addr2", 64'(mem_wr_addr), 64'h0501);
      chk_desc("t3.ok", 8'h05, 11'd10, 2'd0);
      check("t3.pkts", 64'(cnt_pkts), 64'd3);
      pop_one();

      // 191 beats without eop: beat 190 hits the limit
      repeat (2) @(negedge clk_host);
      wr_base = wr_count;
      send(1, 0, 8'h20, 3'd0, 64'h0);
      for (int i = 1; i <= 190; i++) begin
         send(0, 0, 8'h20, 3'd0, 64'(i));
         if (i == 189) check("t4.last_addr", 64'(mem_wr_addr), 64'h20BD);
      end
      check("t4.no_wr", 64'(mem_wr_en), 64'd0);
      chk_desc("t4.over", 8'h20, 11'd1520, 2'd2);
      check("t4.errs", 64'(cnt_errs), 64'd2);
      send(0, 1, 8'h20, 3'd0, 64'hFF);
      check("t4.disc_wr", 64'(mem_wr_en), 64'd0);
      @(negedge clk_host);
      check("t4.nwr", 64'(wr_count - wr_base), 64'd190);
      pop_one();
      check("t4.one_desc", 64'(desc_valid), 64'd0);
      send(1, 1, 8'h21, 3'd0, 64'h21);
      chk_desc("t4.idle", 8'h21, 11'd1, 2'd0);
      pop_one();

      // descriptor FIFO overflow, then push+pop while full
      for (int i = 0; i < 5; i++) send(1, 1, 8'(8'h40 + i), 3'd0, 64'(i));
      check("t5.drops", 64'(cnt_drops), 64'd1);
      check("t5.pkts", 64'(cnt_pkts), 64'd9);
      chk_desc("t5.head", 8'h40, 11'd1, 2'd0);
      desc_ready = 1'b1;
      send(1, 1, 8'h50, 3'd0, 64'h50);
      desc_ready = 1'b0;
      check("t5.nodrop", 64'(cnt_drops), 64'd1);
      check("t5.pkts2", 64'(cnt_pkts), 64'd10);
      check("t5.h1", 64'(desc_buffer), 64'h41);
      pop_one();
      check("t5.h2", 64'(desc_buffer), 64'h42);
      pop_one();
      check("t5.h3", 64'(desc_buffer), 64'h43);
      pop_one();
      check("t5.h4", 64'(desc_buffer), 64'h50);
      pop_one();
      check("t5.empty", 64'(desc_valid), 64'd0);

      // buffer mismatch mid-packet, then discard until eop
      send(1, 0, 8'h70, 3'd0, 64'h70);
      send(0, 0, 8'h71, 3'd0, 64'h71);
      check("t6.mism_wr", 64'(mem_wr_en), 64'd0);
      chk_desc("t6.mism", 8'h70, 11'd8, 2'd3);
      check("t6.errs", 64'(cnt_errs), 64'd3);
      send(0, 1, 8'h70, 3'd0, 64'h72);
      check("t6.disc_wr", 64'(mem_wr_en), 64'd0);
      pop_one();
      check("t6.one_desc", 64'(desc_valid), 64'd0);

      // orphan beat in IDLE
      send(0, 0, 8'h60, 3'd0, 64'h60);
      check("t7.orphan_wr", 64'(mem_wr_en), 64'd0);
      check("t7.errs", 64'(cnt_errs), 64'd4);

      // reset in the middle of a packet
      send(1, 0, 8'h61, 3'd0, 64'h61);
      send(0, 0, 8'h61, 3'd0, 64'h62);
      rst_n = 1'b0;
      repeat (2) @(negedge clk_host);
      check("t8.wr_en", 64'(mem_wr_en), 64'd0);
      check("t8.addr", 64'(mem_wr_addr), 64'd0);
      check("t8.data", mem_wr_data, 64'd0);
      check("t8.dvalid", 64'(desc_valid), 64'd0);
      check("t8.dbuf", 64'(desc_buffer), 64'd0);
      check("t8.dbytes", 64'(desc_bytes), 64'd0);
      check("t8.derr", 64'(desc_err), 64'd0);
      check("t8.pkts", 64'(cnt_pkts), 64'd0);
      check("t8.errs", 64'(cnt_errs), 64'd0);
      check("t8.drops", 64'(cnt_drops), 64'd0);
      rst_n = 1'b1;
      send(0, 1, 8'h61, 3'd7, 64'h63);
      check("t8.post_wr", 64'(mem_wr_en), 64'd0);
      check("t8.post_desc", 64'(desc_valid), 64'd0);
      check("t8.post_errs", 64'(cnt_errs), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
